// File: rtl/nibble_assembler.sv
// Pairs strobed 4-bit nibbles (low first) from a 5-bit link into bytes and queues them
// in a show-ahead FIFO drained over valid/ready; flags timeouts and overflow.
module nibble_assembler #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    link_in,
  output logic [7:0]    byte_data,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic          frame_err
);
  typedef enum logic {LO, HI} state_t;

  state_t        state;
  logic [4:0]    link_q;
  logic          link_qd;
  logic [3:0]    lo_nib;
  logic [TW-1:0] timer;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          stb, push, pop, push_ok;

  // Falling edge of the registered strobe; a held-low strobe yields one event.
  assign stb     = link_qd & ~link_q[4];
  assign push    = (state == HI) & stb;
  assign pop     = byte_valid & byte_ready;
  // A full FIFO still takes the byte if the head leaves on the same edge.
  assign push_ok = push & ((count != (AW+1)'(DEPTH)) | pop);

  assign byte_valid = (count != '0);
  assign byte_data  = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      link_q    <= 5'h1F;
      link_qd   <= 1'b1;
      state     <= LO;
      lo_nib    <= '0;
      timer     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      link_q    <= link_in;
      link_qd   <= link_q[4];
      frame_err <= 1'b0;
      case (state)
        LO: if (stb) begin
          lo_nib <= link_q[3:0];
          timer  <= '0;
          state  <= HI;
        end
        HI: if (stb) begin
          state <= LO;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          frame_err <= 1'b1;
          state     <= LO;
        end else begin
          timer <= timer + TW'(1);
        end
        default: state <= LO;
      endcase
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push & ~push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {link_q[3:0], lo_nib};
  end
endmodule
